// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared state encoding, error codes and defaults for the UART frame decoder
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_OP      = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4,
        ST_HOLD    = 3'd5
    } state_t;

    localparam logic [2:0] ERR_CHECKSUM = 3'd0;
    localparam logic [2:0] ERR_LEN      = 3'd1;
    localparam logic [2:0] ERR_FRAMING  = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
    localparam logic [2:0] ERR_OVERRUN  = 3'd4;

    localparam logic [7:0] SOF_DEFAULT  = 8'hA5;

endpackage

// File: rtl/uart_frame_chk.sv
// rtl/uart_frame_chk.sv - next running check value; XOR by default, CRC-8 (poly 0x07) with UART_FRAME_CRC8_EN
module uart_frame_chk (
    input  logic [7:0] cur,
    input  logic [7:0] byte_in,
    output logic [7:0] next
);

`ifdef UART_FRAME_CRC8_EN
    // MSB-first CRC-8, one byte per call, no reflection and no final XOR
    always_comb begin
        logic [7:0] c;
        c = cur ^ byte_in;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        next = c;
    end
`else
    // plain longitudinal XOR
    always_comb begin
        next = cur ^ byte_in;
    end
`endif

endmodule

// File: rtl/uart_frame_decoder.sv
// rtl/uart_frame_decoder.sv - assembles SOF/OP/LEN/payload/CHK host frames; UART_FRAME_CRC8_EN selects CRC-8 check
module uart_frame_decoder
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SOF            = SOF_DEFAULT,
    parameter int         MAX_LEN        = 4,
    parameter int         TIMEOUT_CYCLES = 50000,
    localparam int        LW             = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 anrst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_done,
    input  logic                 rx_err,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [7:0]           cmd_op,
    output logic [LW-1:0]        cmd_len,
    output logic [8*MAX_LEN-1:0] cmd_payload,
    output logic                 frame_err,
    output logic [2:0]           err_code
);

    localparam int             IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int             TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit             TO_EN     = (TIMEOUT_CYCLES > 0);
    localparam logic [TW-1:0]  TO_LOAD   = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

    state_t               state_q, state_d;
    logic [7:0]           chk_q, chk_d, chk_upd;
    logic [TW-1:0]        to_q, to_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [7:0]           op_q, op_d;
    logic [LW-1:0]        len_q, len_d;
    logic [8*MAX_LEN-1:0] pay_q, pay_d;
    logic                 err_q, err_d;
    logic [2:0]           code_q, code_d;

    logic                 is_byte;
    logic                 in_frame;
    logic                 expired;
    logic                 fail;
    logic [2:0]           fail_code;

    // a receiver error in the same cycle as rx_done voids the byte
    assign is_byte  = rx_done & ~rx_err;
    assign in_frame = (state_q == ST_OP) || (state_q == ST_LEN) ||
                      (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
    // fires on the cycle the inter-byte counter decrements to zero
    assign expired  = TO_EN && (to_q <= TW'(1));

    uart_frame_chk u_chk (
        .cur     (chk_q),
        .byte_in (rx_data),
        .next    (chk_upd)
    );

    // next-state, datapath and error selection
    always_comb begin
        state_d   = state_q;
        chk_d     = chk_q;
        to_d      = to_q;
        idx_d     = idx_q;
        op_d      = op_q;
        len_d     = len_q;
        pay_d     = pay_q;
        err_d     = 1'b0;
        code_d    = code_q;
        fail      = 1'b0;
        fail_code = ERR_CHECKSUM;

        if (in_frame && (to_q != '0)) begin
            to_d = to_q - TW'(1);
        end

        if (in_frame && rx_err) begin
            fail      = 1'b1;
            fail_code = ERR_FRAMING;
        end else if (in_frame && !is_byte && expired) begin
            fail      = 1'b1;
            fail_code = ERR_TIMEOUT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_byte && (rx_data == SOF)) begin
                        state_d = ST_OP;
                        chk_d   = 8'h00;
                        to_d    = TO_LOAD;
                    end
                end
                ST_OP: begin
                    if (is_byte) begin
                        op_d    = rx_data;
                        pay_d   = '0;
                        chk_d   = chk_upd;
                        to_d    = TO_LOAD;
                        state_d = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (is_byte) begin
                        if (rx_data > MAX_LEN_B) begin
                            fail      = 1'b1;
                            fail_code = ERR_LEN;
                        end else begin
                            len_d   = rx_data[LW-1:0];
                            idx_d   = '0;
                            chk_d   = chk_upd;
                            to_d    = TO_LOAD;
                            state_d = (rx_data == 8'h00) ? ST_CHK : ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (is_byte) begin
                        pay_d[8*idx_q +: 8] = rx_data;
                        idx_d = idx_q + IW'(1);
                        chk_d = chk_upd;
                        to_d  = TO_LOAD;
                        if (int'(idx_q) == int'(len_q) - 1) begin
                            state_d = ST_CHK;
                        end
                    end
                end
                ST_CHK: begin
                    if (is_byte) begin
                        if (rx_data == chk_q) begin
                            state_d = ST_HOLD;
                        end else begin
                            fail      = 1'b1;
                            fail_code = ERR_CHECKSUM;
                        end
                    end
                end
                ST_HOLD: begin
                    // the held command is never overwritten; stray bytes are only reported
                    if (is_byte) begin
                        err_d  = 1'b1;
                        code_d = ERR_OVERRUN;
                    end
                    if (cmd_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (fail) begin
            err_d   = 1'b1;
            code_d  = fail_code;
            state_d = ST_IDLE;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            state_q <= ST_IDLE;
            chk_q   <= 8'h00;
            to_q    <= '0;
            idx_q   <= '0;
            op_q    <= 8'h00;
            len_q   <= '0;
            pay_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            chk_q   <= chk_d;
            to_q    <= to_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            len_q   <= len_d;
            pay_q   <= pay_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign cmd_valid   = (state_q == ST_HOLD);
    assign cmd_op      = op_q;
    assign cmd_len     = len_q;
    assign cmd_payload = pay_q;
    assign frame_err   = err_q;
    assign err_code    = code_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb/tb_uart_frame_decoder.sv - directed table and corner-case bench for uart_frame_decoder
module tb_uart_frame_decoder;

    logic        clk;
    logic        anrst;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        rx_err;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_op;
    logic [2:0]  cmd_len;
    logic [31:0] cmd_payload;
    logic        frame_err;
    logic [2:0]  err_code;

    int tests = 0;
    int fails = 0;

    int          valid_seen = 0;
    int          err_seen   = 0;
    logic [7:0]  cap_op     = 8'h00;
    logic [2:0]  cap_len    = 3'd0;
    logic [31:0] cap_pay    = 32'h0;
    logic [2:0]  cap_code   = 3'd0;

    uart_frame_decoder #(
        .SOF            (8'hA5),
        .MAX_LEN        (4),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk         (clk),
        .anrst       (anrst),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .rx_err      (rx_err),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_len     (cmd_len),
        .cmd_payload (cmd_payload),
        .frame_err   (frame_err),
        .err_code    (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_valid) begin
            valid_seen <= valid_seen + 1;
            cap_op     <= cmd_op;
            cap_len    <= cmd_len;
            cap_pay    <= cmd_payload;
        end
        if (frame_err) begin
            err_seen <= err_seen + 1;
            cap_code <= err_code;
        end
    end

    typedef struct {
        logic [95:0] body;
        int          nb;
        bit          has_chk;
        logic [7:0]  corrupt;
        int          exp_valid;
        logic [7:0]  exp_op;
        logic [2:0]  exp_len;
        logic [31:0] exp_pay;
        int          exp_err;
        logic [2:0]  exp_code;
    } vec_t;

    localparam int NV = 7;
    vec_t tv [NV];

    function automatic logic [7:0] ref_step(input logic [7:0] c, input logic [7:0] b);
`ifdef UART_FRAME_CRC8_EN
        logic [7:0] r;
        r = c ^ b;
        for (int i = 0; i < 8; i++) begin
            if (r[7]) r = {r[6:0], 1'b0} ^ 8'h07;
            else      r = {r[6:0], 1'b0};
        end
        return r;
`else
        return c ^ b;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] c;
        logic [7:0] b;
        logic [7:0] good_chk;
        bit         started;
        int         v0;
        int         e0;
        int         first;
        logic [2:0] code;

        // body byte 0 is the rightmost byte of each concatenation; check byte is appended by the bench
        tv[0] = '{ {56'h0, 8'h22, 8'h11, 8'h02, 8'h01, 8'hA5}, 5, 1'b1, 8'h00,
                   1, 8'h01, 3'd2, 32'h0000_2211, 0, 3'd0 };
        tv[1] = '{ {56'h0, 8'h22, 8'h11, 8'h02, 8'h01, 8'hA5}, 5, 1'b1, 8'h01,
                   0, 8'h00, 3'd0, 32'h0, 1, 3'd0 };
        tv[2] = '{ {72'h0, 8'h00, 8'h07, 8'hA5}, 3, 1'b1, 8'h00,
                   1, 8'h07, 3'd0, 32'h0, 0, 3'd0 };
        tv[3] = '{ {56'h0, 8'h22, 8'h11, 8'h05, 8'h01, 8'hA5}, 5, 1'b0, 8'h00,
                   0, 8'h00, 3'd0, 32'h0, 1, 3'd1 };
        tv[4] = '{ {24'h0, 8'h04, 8'h03, 8'h02, 8'h01, 8'h04, 8'h10, 8'hA5, 8'h3C, 8'h00}, 9, 1'b1, 8'h00,
                   1, 8'h10, 3'd4, 32'h0403_0201, 0, 3'd0 };
        tv[5] = '{ {64'h0, 8'hFF, 8'h01, 8'h20, 8'hA5}, 4, 1'b1, 8'h00,
                   1, 8'h20, 3'd1, 32'h0000_00FF, 0, 3'd0 };
        tv[6] = '{ {48'h0, 8'hCC, 8'hBB, 8'hAA, 8'h03, 8'hA5, 8'hA5}, 6, 1'b1, 8'h00,
                   1, 8'hA5, 3'd3, 32'h00CC_BBAA, 0, 3'd0 };

        anrst     = 1'b0;
        rx_data   = 8'h00;
        rx_done   = 1'b0;
        rx_err    = 1'b0;
        cmd_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_valid", {31'b0, cmd_valid}, 32'd0);
        check("rst_op", {24'b0, cmd_op}, 32'd0);
        check("rst_len", {29'b0, cmd_len}, 32'd0);
        check("rst_pay", cmd_payload, 32'd0);
        check("rst_err", {31'b0, frame_err}, 32'd0);
        check("rst_code", {29'b0, err_code}, 32'd0);
        @(posedge clk);
        #1;
        anrst = 1'b1;
        idle(2);

        for (int v = 0; v < NV; v++) begin
            v0 = valid_seen;
            e0 = err_seen;
            c = 8'h00;
            started = 1'b0;
            for (int i = 0; i < tv[v].nb; i++) begin
                b = tv[v].body[8*i +: 8];
                send_byte(b);
                if (started)           c = ref_step(c, b);
                else if (b == 8'hA5)   started = 1'b1;
            end
            if (tv[v].has_chk) send_byte(c ^ tv[v].corrupt);
            idle(3);
            check($sformatf("v%0d_valid_cnt", v), valid_seen - v0, tv[v].exp_valid);
            check($sformatf("v%0d_err_cnt", v), err_seen - e0, tv[v].exp_err);
            if (tv[v].exp_valid != 0) begin
                check($sformatf("v%0d_op", v), {24'b0, cap_op}, {24'b0, tv[v].exp_op});
                check($sformatf("v%0d_len", v), {29'b0, cap_len}, {29'b0, tv[v].exp_len});
                check($sformatf("v%0d_pay", v), cap_pay, tv[v].exp_pay);
            end
            if (tv[v].exp_err != 0) begin
                check($sformatf("v%0d_code", v), {29'b0, cap_code}, {29'b0, tv[v].exp_code});
            end
        end

        // literal check bytes for OP=01 LEN=0
`ifdef UART_FRAME_CRC8_EN
        good_chk = 8'h15;
`else
        good_chk = 8'h01;
`endif
        v0 = valid_seen;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(good_chk);
        check("lit_latency_valid", {31'b0, cmd_valid}, 32'd1);
        idle(1);
        check("lit_valid_drop", {31'b0, cmd_valid}, 32'd0);
        check("lit_valid_cnt", valid_seen - v0, 32'd1);
        e0 = err_seen;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        check("lit_bad_err", {31'b0, frame_err}, 32'd1);
        check("lit_bad_code", {29'b0, err_code}, 32'd0);

        // length error reported exactly one cycle after the LEN byte
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h05);
        check("len_err_pulse", {31'b0, frame_err}, 32'd1);
        check("len_err_code", {29'b0, err_code}, 32'd1);
        idle(1);
        check("len_err_single", {31'b0, frame_err}, 32'd0);

        // inter-byte timeout: pulse 20 cycles after the OP byte
        send_byte(8'hA5); send_byte(8'h01);
        first = -1;
        code  = 3'd7;
        for (int k = 1; k <= 25; k++) begin
            if (frame_err && first < 0) begin
                first = k;
                code  = err_code;
            end
            idle(1);
        end
        check("timeout_cycle", first, 20);
        check("timeout_code", {29'b0, code}, 32'd3);

        // receiver framing error inside a frame
        send_byte(8'hA5);
        rx_err = 1'b1;
        idle(1);
        rx_err = 1'b0;
        check("framing_pulse", {31'b0, frame_err}, 32'd1);
        check("framing_code", {29'b0, err_code}, 32'd2);

        // backpressure and overrun while holding a command
        cmd_ready = 1'b0;
        c = ref_step(ref_step(ref_step(8'h00, 8'h01), 8'h01), 8'h55);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01); send_byte(8'h55); send_byte(c);
        idle(3);
        check("hold_valid", {31'b0, cmd_valid}, 32'd1);
        check("hold_pay", cmd_payload, 32'h55);
        send_byte(8'h40);
        check("ovr_pulse", {31'b0, frame_err}, 32'd1);
        check("ovr_code", {29'b0, err_code}, 32'd4);
        check("ovr_valid_kept", {31'b0, cmd_valid}, 32'd1);
        check("ovr_op_kept", {24'b0, cmd_op}, 32'h01);
        check("ovr_len_kept", {29'b0, cmd_len}, 32'd1);
        check("ovr_pay_kept", cmd_payload, 32'h55);
        v0 = valid_seen;
        cmd_ready = 1'b1;
        idle(1);
        cmd_ready = 1'b0;
        check("hs_valid_drop", {31'b0, cmd_valid}, 32'd0);
        idle(3);
        check("hs_single", valid_seen - v0, 32'd1);

        // overrun on the handshake cycle, then SOF immediately after
        c = ref_step(ref_step(8'h00, 8'h02), 8'h00);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(c);
        idle(2);
        cmd_ready = 1'b1;
        rx_data   = 8'h77;
        rx_done   = 1'b1;
        idle(1);
        rx_done   = 1'b0;
        rx_data   = 8'h00;
        check("hs_ovr_pulse", {31'b0, frame_err}, 32'd1);
        check("hs_ovr_code", {29'b0, err_code}, 32'd4);
        check("hs_ovr_valid", {31'b0, cmd_valid}, 32'd0);
        v0 = valid_seen;
        c = ref_step(ref_step(8'h00, 8'h03), 8'h00);
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00); send_byte(c);
        idle(3);
        check("b2b_valid_cnt", valid_seen - v0, 32'd1);
        check("b2b_op", {24'b0, cap_op}, 32'h03);

        // reset mid-frame drops the frame silently
        e0 = err_seen;
        send_byte(8'hA5); send_byte(8'h01);
        anrst = 1'b0;
        @(negedge clk);
        check("midrst_op", {24'b0, cmd_op}, 32'd0);
        check("midrst_valid", {31'b0, cmd_valid}, 32'd0);
        check("midrst_code", {29'b0, err_code}, 32'd0);
        @(posedge clk);
        #1;
        anrst = 1'b1;
        v0 = valid_seen;
        c = ref_step(ref_step(ref_step(ref_step(8'h00, 8'h09), 8'h02), 8'h12), 8'h34);
        send_byte(8'hA5); send_byte(8'h09); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34); send_byte(c);
        idle(3);
        check("midrst_no_err", err_seen - e0, 32'd0);
        check("midrst_next_cnt", valid_seen - v0, 32'd1);
        check("midrst_next_op", {24'b0, cap_op}, 32'h09);
        check("midrst_next_pay", cap_pay, 32'h0000_3412);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
